// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared constants for the VGA timing generator. Holds the
//                default 640x480@60 timing, the test-pattern encodings and a
//                helper that sums the four segments of one scan axis.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

  // Default 640x480@60 horizontal timing (pixels)
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;

  // Default 640x480@60 vertical timing (lines)
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  // Test-pattern selector encodings
  localparam logic [1:0] PAT_SOLID  = 2'd0;
  localparam logic [1:0] PAT_BARS   = 2'd1;
  localparam logic [1:0] PAT_CHECK  = 2'd2;
  localparam logic [1:0] PAT_BORDER = 2'd3;

  // Total length of one scan axis: active + front porch + sync + back porch
  function automatic int unsigned axis_total(input int unsigned active,
                                             input int unsigned fp,
                                             input int unsigned sync,
                                             input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  localparam int unsigned DEF_H_TOTAL =
    axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int unsigned DEF_V_TOTAL =
    axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
//  Module      : vga_axis_counter
//  Description : One scan axis (horizontal or vertical). A wrapping position
//                counter advanced by en_i, plus the combinational decode of
//                the current position: terminal-count strobe, sync level and
//                active-region flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned FP     = DEF_H_FP,
  parameter int unsigned SYNC   = DEF_H_SYNC,
  parameter int unsigned BP     = DEF_H_BP,
  parameter logic        POL    = 1'b0,
  parameter int unsigned CW     = 10
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  output logic [CW-1:0] count_o,
  output logic          wrap_o,
  output logic          sync_o,
  output logic          active_o
);

  localparam int unsigned   TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACT_END    = CW'(ACTIVE);
  localparam logic [CW-1:0] SYNC_START = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] SYNC_END   = CW'(ACTIVE + FP + SYNC);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          w_at_last;

  // Next position and position decode
  always_comb begin
    w_at_last = (count_q == LAST);
    count_d   = count_q;
    if (en_i) begin
      count_d = w_at_last ? '0 : count_q + 1'b1;
    end
    wrap_o   = en_i & w_at_last;
    sync_o   = ((count_q >= SYNC_START) && (count_q < SYNC_END)) ? POL : ~POL;
    active_o = (count_q < ACT_END);
  end

  // Position register; holds whenever en_i is low
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Parametrised VGA timing and test-pattern generator. Two axis
//                counters track the raster position; every pixel tick loads
//                registered syncs, coordinates, strobes and an RGB test
//                pattern decoded from the position before it advances.
//                Pattern selection and colour are sampled at the frame origin
//                so a frame is always drawn with one consistent setting.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter logic        H_POL    = 1'b0,
  parameter logic        V_POL    = 1'b0,
  parameter int unsigned CBITS    = 1,
  parameter int unsigned CHK_LOG2 = 5,
  parameter int unsigned CW       = 10
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               pix_en_i,
  input  logic [1:0]         pattern_sel_i,
  input  logic [3*CBITS-1:0] color_i,
  output logic [CW-1:0]      pixel_x_o,
  output logic [CW-1:0]      pixel_y_o,
  output logic               video_on_o,
  output logic               h_sync_o,
  output logic               v_sync_o,
  output logic               line_start_o,
  output logic               frame_start_o,
  output logic [3*CBITS-1:0] rgb_o
);

  // Colour bars are H_ACTIVE/8 wide; narrow screens fall back to width 1
  localparam int unsigned   BAR_W       = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;
  localparam logic [CW-1:0] BAR_DIV     = CW'(BAR_W);
  localparam logic [CW-1:0] BAR_MAX     = CW'(7);
  localparam logic [CW-1:0] X_LAST_VIS  = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] Y_LAST_VIS  = CW'(V_ACTIVE - 1);

  // Raster position and its decode
  logic [CW-1:0] w_hc;
  logic [CW-1:0] w_vc;
  logic          w_h_wrap;
  logic          w_unused_v_wrap;
  logic          w_h_sync;
  logic          w_v_sync;
  logic          w_h_active;
  logic          w_v_active;

  // Frame-sampled pattern controls
  logic [1:0]         pattern_q;
  logic [3*CBITS-1:0] color_q;

  // Output registers and their next-state values
  logic [CW-1:0]      pixel_x_q;
  logic [CW-1:0]      pixel_y_q;
  logic               video_on_q;
  logic               h_sync_q;
  logic               v_sync_q;
  logic               line_start_q;
  logic               frame_start_q;
  logic [3*CBITS-1:0] rgb_q;
  logic [3*CBITS-1:0] rgb_d;

  // Pattern decode helpers
  logic               w_origin;
  logic [1:0]         w_pat;
  logic [3*CBITS-1:0] w_col;
  logic [CW-1:0]      w_bar_idx;
  logic [2:0]         w_bar;
  logic               w_visible;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (H_POL),
    .CW     (CW)
  ) u_h_axis (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en_i     (pix_en_i),
    .count_o  (w_hc),
    .wrap_o   (w_h_wrap),
    .sync_o   (w_h_sync),
    .active_o (w_h_active)
  );

  // The vertical axis steps once per completed line
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (V_POL),
    .CW     (CW)
  ) u_v_axis (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en_i     (w_h_wrap),
    .count_o  (w_vc),
    .wrap_o   (w_unused_v_wrap),
    .sync_o   (w_v_sync),
    .active_o (w_v_active)
  );

  // Test-pattern colour for the current position; the origin tick uses the
  // freshly presented controls so capture and use coincide
  always_comb begin
    w_origin  = (w_hc == '0) && (w_vc == '0);
    w_pat     = w_origin ? pattern_sel_i : pattern_q;
    w_col     = w_origin ? color_i : color_q;
    w_visible = w_h_active & w_v_active;
    w_bar_idx = w_hc / BAR_DIV;
    w_bar     = (w_bar_idx > BAR_MAX) ? 3'd7 : w_bar_idx[2:0];
    rgb_d     = '0;
    if (w_visible) begin
      case (w_pat)
        PAT_SOLID:  rgb_d = w_col;
        PAT_BARS:   rgb_d = {{CBITS{w_bar[2]}}, {CBITS{w_bar[1]}}, {CBITS{w_bar[0]}}};
        PAT_CHECK:  rgb_d = (w_hc[CHK_LOG2] ^ w_vc[CHK_LOG2]) ? ~w_col : w_col;
        PAT_BORDER: rgb_d = ((w_hc == '0) || (w_hc == X_LAST_VIS) ||
                             (w_vc == '0) || (w_vc == Y_LAST_VIS)) ? '1 : '0;
        default:    rgb_d = '0;
      endcase
    end
  end

  // Output and control registers; everything holds while pix_en_i is low
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      video_on_q    <= 1'b0;
      h_sync_q      <= ~H_POL;
      v_sync_q      <= ~V_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      rgb_q         <= '0;
      pattern_q     <= PAT_SOLID;
      color_q       <= '0;
    end else if (pix_en_i) begin
      pixel_x_q     <= w_hc;
      pixel_y_q     <= w_vc;
      video_on_q    <= w_visible;
      h_sync_q      <= w_h_sync;
      v_sync_q      <= w_v_sync;
      line_start_q  <= (w_hc == '0);
      frame_start_q <= w_origin;
      rgb_q         <= rgb_d;
      if (w_origin) begin
        pattern_q <= pattern_sel_i;
        color_q   <= color_i;
      end
    end
  end

  assign pixel_x_o     = pixel_x_q;
  assign pixel_y_o     = pixel_y_q;
  assign video_on_o    = video_on_q;
  assign h_sync_o      = h_sync_q;
  assign v_sync_o      = v_sync_q;
  assign line_start_o  = line_start_q;
  assign frame_start_o = frame_start_q;
  assign rgb_o         = rgb_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Self-checking bench for vga_timing_gen using a reduced
//                raster with mixed sync polarity, 2-bit colour and a bar
//                width that forces bar-index saturation. Expected pixels come
//                from the pixel-tick count since reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int   HA = 20, HF = 3, HS = 4, HB = 2;
  localparam int   VA = 10, VF = 2, VS = 2, VB = 3;
  localparam int   HT = HA + HF + HS + HB;
  localparam int   VT = VA + VF + VS + VB;
  localparam int   FRAME = HT * VT;
  localparam logic HPOL = 1'b1;
  localparam logic VPOL = 1'b0;
  localparam int   CB = 2;
  localparam int   CBW = 3 * CB;
  localparam int   CHK = 2;
  localparam int   CW = 6;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           pix_en = 1'b0;
  logic [1:0]     psel = 2'd0;
  logic [CBW-1:0] col = '0;
  logic [CW-1:0]  pixel_x, pixel_y;
  logic           video_on, h_sync, v_sync, line_start, frame_start;
  logic [CBW-1:0] rgb;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(HPOL), .V_POL(VPOL), .CBITS(CB), .CHK_LOG2(CHK), .CW(CW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .pix_en_i(pix_en),
    .pattern_sel_i(psel), .color_i(col),
    .pixel_x_o(pixel_x), .pixel_y_o(pixel_y), .video_on_o(video_on),
    .h_sync_o(h_sync), .v_sync_o(v_sync), .line_start_o(line_start),
    .frame_start_o(frame_start), .rgb_o(rgb)
  );

  typedef struct packed {
    logic [CW-1:0]  x;
    logic [CW-1:0]  y;
    logic           von;
    logic           hs;
    logic           vs;
    logic           ls;
    logic           fs;
    logic [CBW-1:0] rgb;
  } obs_t;

  obs_t act;
  always_comb act = {pixel_x, pixel_y, video_on, h_sync, v_sync, line_start, frame_start, rgb};

  obs_t           exp_q[$];
  obs_t           last_exp;
  int             checks = 0;
  int             failures = 0;
  int             n = 0;
  logic [1:0]     mpat = 2'd0;
  logic [CBW-1:0] mcol = '0;

  function automatic obs_t reset_obs();
    obs_t o;
    o     = '0;
    o.hs  = ~HPOL;
    o.vs  = ~VPOL;
    return o;
  endfunction

  // Reference: the k-th pixel tick since reset sits at (k mod HT, k div HT mod VT)
  function automatic obs_t model(int k, logic [1:0] pat, logic [CBW-1:0] c);
    obs_t o;
    int   x, y, b;
    x     = k % HT;
    y     = (k / HT) % VT;
    o.x   = x[CW-1:0];
    o.y   = y[CW-1:0];
    o.von = (x < HA) && (y < VA);
    o.hs  = (x >= HA + HF && x < HA + HF + HS) ? HPOL : ~HPOL;
    o.vs  = (y >= VA + VF && y < VA + VF + VS) ? VPOL : ~VPOL;
    o.ls  = (x == 0);
    o.fs  = (x == 0) && (y == 0);
    o.rgb = '0;
    if (o.von) begin
      case (pat)
        2'd0: o.rgb = c;
        2'd1: begin
          b = x / (HA / 8);
          if (b > 7) b = 7;
          o.rgb = {{CB{b[2]}}, {CB{b[1]}}, {CB{b[0]}}};
        end
        2'd2: o.rgb = ((((x >> CHK) ^ (y >> CHK)) & 1) != 0) ? ~c : c;
        default: o.rgb = (x == 0 || x == HA - 1 || y == 0 || y == VA - 1) ? '1 : '0;
      endcase
    end
    return o;
  endfunction

  task automatic check(input string name, input obs_t a, input obs_t e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s t=%0t: got x=%0d y=%0d von=%b hs=%b vs=%b ls=%b fs=%b rgb=%h, expected x=%0d y=%0d von=%b hs=%b vs=%b ls=%b fs=%b rgb=%h",
               name, $time, a.x, a.y, a.von, a.hs, a.vs, a.ls, a.fs, a.rgb,
               e.x, e.y, e.von, e.hs, e.vs, e.ls, e.fs, e.rgb);
    end
  endtask

  // Drive one clock of stimulus; an enabled tick pushes its expected pixel
  task automatic step(input logic en, input bit chg);
    @(negedge clk);
    pix_en = en;
    if (chg && ($urandom_range(0, 63) == 0)) psel = 2'($urandom_range(0, 3));
    if (chg && ($urandom_range(0, 63) == 0)) col  = CBW'($urandom);
    if (en) begin
      if ((n % FRAME) == 0) begin
        mpat = psel;
        mcol = col;
      end
      exp_q.push_back(model(n, mpat, mcol));
      n++;
    end
  endtask

  // Assert reset between clock edges and confirm outputs clear immediately
  task automatic do_reset();
    @(negedge clk);
    pix_en = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("async_reset", act, reset_obs());
    exp_q.delete();
    n    = 0;
    mpat = 2'd0;
    mcol = '0;
    repeat (3) @(negedge clk);
    pix_en = 1'b0;
    rst_n  = 1'b1;
  endtask

  // Monitor: every enabled tick presents a new pixel, otherwise outputs hold
  initial begin
    logic en_s, rst_s;
    obs_t e;
    last_exp = reset_obs();
    forever begin
      @(posedge clk);
      en_s  = pix_en;
      rst_s = rst_n;
      #1;
      if (!rst_s) begin
        last_exp = reset_obs();
        check("reset_hold", act, last_exp);
      end else if (en_s) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL underflow t=%0t: DUT tick with no expected pixel queued", $time);
        end else begin
          e = exp_q.pop_front();
          check("pixel", act, e);
          last_exp = e;
        end
      end else begin
        check("hold", act, last_exp);
      end
    end
  end

  initial begin
    int guard;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Continuous ticks, colour bars, two full frames
    psel = PAT_BARS;
    repeat (2 * FRAME) step(1'b1, 1'b0);

    // Checkerboard with the pixel enable toggling every other clock
    psel = PAT_CHECK;
    col  = CBW'($urandom);
    for (int i = 0; i < 2 * FRAME; i++) step(1'(i % 2), 1'b0);

    // Random enables with occasional mid-frame control changes
    repeat (1500) step(1'($urandom_range(0, 3) != 0), 1'b1);

    // Border pattern for a full frame after the current one ends
    psel = PAT_BORDER;
    repeat (2 * FRAME) step(1'b1, 1'b0);

    // Run into the middle of a frame, then reset asynchronously
    psel  = PAT_SOLID;
    col   = CBW'($urandom);
    guard = 0;
    while (((n % FRAME) != (VT / 2) * HT + HT / 2) && guard < 2 * FRAME) begin
      step(1'b1, 1'b0);
      guard++;
    end
    do_reset();

    // Restart from the origin under random traffic
    repeat (1200) step(1'($urandom_range(0, 2) != 0), 1'b1);

    @(negedge clk);
    pix_en = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected pixels never presented, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
